// File: rtl/glenn_record_tx_pkg.sv
// glenn_record_tx_pkg
// Shared definitions for the record/transmit block:
//   - state_t            : frame FSM state encoding
//   - DEFAULT_SYNC_BYTE  : default first byte of every frame
//   - occ_width()        : width of an occupancy counter that can hold 0..DEPTH
// Optional feature macro used by importers: GLENN_RECORD_TX_SEQ_EN.
package glenn_record_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEN  = 3'd2,
        ST_SEQ  = 3'd3,
        ST_DATA = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // One extra bit beyond the pointer width so a full buffer (count == DEPTH)
    // is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/glenn_sample_fifo.sv
// glenn_sample_fifo
// Single-clock DEPTH x 8 sample buffer. DEPTH must be a power of two so both
// pointers wrap naturally modulo DEPTH.
// Ports:
//   in_Clk, in_Rst        clock, asynchronous active-high reset
//   in_Wr / in_WrData     write strobe and data (ignored when full)
//   in_Pop                advance read pointer (ignored when empty)
//   out_Head              entry at the read pointer
//   out_NextHead          entry after the read pointer (head after a pop)
//   out_Full / out_Empty  occupancy == DEPTH / occupancy == 0
//   out_Count             registered occupancy
module glenn_sample_fifo
    import glenn_record_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        in_Clk,
    input  logic                        in_Rst,
    input  logic                        in_Wr,
    input  logic [7:0]                  in_WrData,
    input  logic                        in_Pop,
    output logic [7:0]                  out_Head,
    output logic [7:0]                  out_NextHead,
    output logic                        out_Full,
    output logic                        out_Empty,
    output logic [occ_width(DEPTH)-1:0] out_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic          wr_ok;
    logic          pop_ok;

    assign out_Full    = (count_reg == CW'(DEPTH));
    assign out_Empty   = (count_reg == '0);
    assign wr_ok       = in_Wr & ~out_Full;
    assign pop_ok      = in_Pop & ~out_Empty;
    assign rd_ptr_next = rd_ptr_reg + AW'(1);

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge in_Clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= in_WrData;
        end
    end

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({wr_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_Head     = mem[rd_ptr_reg];
    assign out_NextHead = mem[rd_ptr_next];
    assign out_Count    = count_reg;

endmodule

// File: rtl/glenn_record_tx.sv
// glenn_record_tx
// Captures one sample per rising edge of the record strobe and, on a rising
// edge of the transmit strobe, sends the buffered samples as the frame
//   SYNC_BYTE, N, [SEQ,] sample_0 .. sample_N-1
// over a valid/ready byte link.
// Ports:
//   in_Clk, in_Rst           clock, asynchronous active-high reset
//   in_1minRecord, in_Data   record strobe (level) and sample value
//   in_5minTransmit          transmit strobe (level)
//   out_TxData, out_TxValid  registered frame byte and valid
//   in_TxReady               downstream accept
//   out_Busy                 frame in progress
//   out_Overflow             sticky: a record edge found the buffer full
//   out_Count                buffer occupancy
// Optional feature: define GLENN_RECORD_TX_SEQ_EN to insert an 8-bit frame
// sequence number after the length byte.
module glenn_record_tx
    import glenn_record_tx_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                        in_Clk,
    input  logic                        in_Rst,
    input  logic                        in_1minRecord,
    input  logic                        in_5minTransmit,
    input  logic [7:0]                  in_Data,
    output logic [7:0]                  out_TxData,
    output logic                        out_TxValid,
    input  logic                        in_TxReady,
    output logic                        out_Busy,
    output logic                        out_Overflow,
    output logic [occ_width(DEPTH)-1:0] out_Count
);

    localparam int CW = occ_width(DEPTH);

    state_t        state_reg;
    logic          rec_prev_reg;
    logic          tx_prev_reg;
    logic [CW-1:0] len_reg;       // N at latch time, then remaining data bytes
    logic [7:0]    tx_data_reg;
    logic          tx_valid_reg;
    logic          overflow_reg;

    logic          rec_event;
    logic          tx_event;
    logic          tx_accept;
    logic          wr_en;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic [7:0]    fifo_next_head;

    // Previous-value registers reset to 1 so a strobe held high through
    // reset release is not mistaken for a fresh edge.
    assign rec_event = in_1minRecord & ~rec_prev_reg;
    assign tx_event  = in_5minTransmit & ~tx_prev_reg;
    assign tx_accept = tx_valid_reg & in_TxReady;
    assign wr_en     = rec_event & ~fifo_full;
    assign pop       = (state_reg == ST_DATA) & tx_accept & ~fifo_empty;

    glenn_sample_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .in_Clk      (in_Clk),
        .in_Rst      (in_Rst),
        .in_Wr       (wr_en),
        .in_WrData   (in_Data),
        .in_Pop      (pop),
        .out_Head    (fifo_head),
        .out_NextHead(fifo_next_head),
        .out_Full    (fifo_full),
        .out_Empty   (fifo_empty),
        .out_Count   (fifo_count)
    );

`ifdef GLENN_RECORD_TX_SEQ_EN
    logic [7:0] seq_reg;
    logic       enter_done;

    assign enter_done = tx_accept &
                        (((state_reg == ST_SEQ)  && (len_reg == '0)) ||
                         ((state_reg == ST_DATA) && (len_reg == CW'(1))));

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            seq_reg <= '0;
        end else if (enter_done) begin
            seq_reg <= seq_reg + 8'd1;
        end
    end
`endif

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            state_reg    <= ST_IDLE;
            rec_prev_reg <= 1'b1;
            tx_prev_reg  <= 1'b1;
            len_reg      <= '0;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            rec_prev_reg <= in_1minRecord;
            tx_prev_reg  <= in_5minTransmit;
            if (rec_event && fifo_full) begin
                overflow_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    // A sample written on this same edge belongs to this frame.
                    if (tx_event) begin
                        len_reg   <= fifo_count + CW'(wr_en);
                        state_reg <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    // First cycle in SYNC loads the sync byte; valid therefore
                    // rises one edge after the transmit event.
                    if (!tx_valid_reg) begin
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= SYNC_BYTE;
                    end else if (in_TxReady) begin
                        tx_data_reg <= 8'(len_reg);
                        state_reg   <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (tx_accept) begin
`ifdef GLENN_RECORD_TX_SEQ_EN
                        tx_data_reg <= seq_reg;
                        state_reg   <= ST_SEQ;
`else
                        if (len_reg == '0) begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= ST_DONE;
                        end else begin
                            tx_data_reg <= fifo_head;
                            state_reg   <= ST_DATA;
                        end
`endif
                    end
                end
                ST_SEQ: begin
                    if (tx_accept) begin
                        if (len_reg == '0) begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= ST_DONE;
                        end else begin
                            tx_data_reg <= fifo_head;
                            state_reg   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // The byte on the link is popped only when accepted; the
                    // following entry is preloaded so throughput stays 1/cycle.
                    if (tx_accept) begin
                        len_reg <= len_reg - CW'(1);
                        if (len_reg == CW'(1)) begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= ST_DONE;
                        end else begin
                            tx_data_reg <= fifo_next_head;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    tx_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_TxData   = tx_data_reg;
    assign out_TxValid  = tx_valid_reg;
    assign out_Busy     = (state_reg != ST_IDLE);
    assign out_Overflow = overflow_reg;
    assign out_Count    = fifo_count;

endmodule

// File: tb/tb_glenn_record_tx.sv
// tb_glenn_record_tx
// Directed bench for glenn_record_tx (DEPTH=8). Each task runs one scenario
// and compares the observed frame bytes, timing and flags against
// hand-computed values. Honours GLENN_RECORD_TX_SEQ_EN.
module tb_glenn_record_tx;

    localparam int DEPTH = 8;
    localparam int CW    = 4;
`ifdef GLENN_RECORD_TX_SEQ_EN
    localparam int SEQX = 1;
`else
    localparam int SEQX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rec;
    logic          tx;
    logic          rdy;
    logic [7:0]    din;
    logic [7:0]    out_TxData;
    logic          out_TxValid;
    logic          out_Busy;
    logic          out_Overflow;
    logic [CW-1:0] out_Count;

    always #5 clk = ~clk;

    glenn_record_tx #(
        .DEPTH(DEPTH)
    ) dut (
        .in_Clk         (clk),
        .in_Rst         (rst),
        .in_1minRecord  (rec),
        .in_5minTransmit(tx),
        .in_Data        (din),
        .out_TxData     (out_TxData),
        .out_TxValid    (out_TxValid),
        .in_TxReady     (rdy),
        .out_Busy       (out_Busy),
        .out_Overflow   (out_Overflow),
        .out_Count      (out_Count)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         seq_exp  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         first_valid;
    int         fall_cyc;
    int         hold_err;
    bit         timed_out;
    bit         rdy_low[64];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rec_edge(input logic [7:0] d);
        din = d;
        rec = 1'b1;
        tick;
        rec = 1'b0;
        tick;
    endtask

    task automatic tx_edge;
        tx = 1'b1;
        tick;
        tx = 1'b0;
    endtask

    // Expected frame header; the bench tracks the sequence number itself.
    task automatic start_exp(input logic [7:0] n);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(n);
`ifdef GLENN_RECORD_TX_SEQ_EN
        exp_q.push_back(seq_exp[7:0]);
`endif
        seq_exp++;
    endtask

    // Runs one frame from just after the transmit edge until out_Busy falls,
    // collecting accepted bytes. Optionally pulses tx/rec mid-frame.
    task automatic capture(input int tx_pulse, input int rec_pulse, input logic [7:0] rec_d);
        logic [7:0] prev_d;
        bit         stalled;
        got_q.delete();
        first_valid = -1;
        fall_cyc    = -1;
        hold_err    = 0;
        timed_out   = 1'b1;
        stalled     = 1'b0;
        prev_d      = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            rdy = (cyc < 64) ? !rdy_low[cyc] : 1'b1;
            tx  = (cyc == tx_pulse);
            rec = (cyc == rec_pulse);
            if (cyc == rec_pulse) din = rec_d;
            if (stalled && (!out_TxValid || out_TxData !== prev_d)) hold_err++;
            if (out_TxValid && first_valid < 0) first_valid = cyc;
            if (!out_Busy) begin
                fall_cyc  = cyc;
                timed_out = 1'b0;
                break;
            end
            if (out_TxValid && rdy) got_q.push_back(out_TxData);
            stalled = out_TxValid && !rdy;
            prev_d  = out_TxData;
            tick;
        end
        tx  = 1'b0;
        rec = 1'b0;
        rdy = 1'b1;
        $display("frame: %0d bytes accepted, busy fell at cycle %0d", got_q.size(), fall_cyc);
    endtask

    task automatic test_reset;
        rst = 1'b1; rec = 1'b1; tx = 1'b1; rdy = 1'b1; din = 8'h00;
        tick; tick;
        n_checks++;
        if ({out_TxValid, out_Busy, out_Overflow} !== 3'b000 || out_TxData !== 8'h00 || out_Count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b busy=%b ovf=%b data=%02h count=%0d, expected all 0",
                     out_TxValid, out_Busy, out_Overflow, out_TxData, out_Count);
        end
        rst = 1'b0;
        tick; tick;
        n_checks++;
        if (out_Count !== 4'd0 || out_Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_strobes: count=%0d busy=%b, expected 0 0", out_Count, out_Busy);
        end
        rec = 1'b0; tx = 1'b0;
        tick;
        $display("reset: done");
    endtask

    task automatic test_basic;
        rec_edge(8'h11); rec_edge(8'h22); rec_edge(8'h33);
        n_checks++;
        if (out_Count !== 4'd3) begin
            n_fail++; $display("FAIL basic_count_pre: got %0d expected 3", out_Count);
        end
        tx_edge;
        capture(-1, -1, 8'h00);
        start_exp(8'h03);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        n_checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_len: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (first_valid != 1) begin
            n_fail++; $display("FAIL basic_latency: first valid at cycle %0d expected 1", first_valid);
        end
        n_checks++;
        if (fall_cyc != 7 + SEQX) begin
            n_fail++; $display("FAIL basic_busy_fall: cycle %0d expected %0d", fall_cyc, 7 + SEQX);
        end
        n_checks++;
        if (out_Count !== 4'd0) begin
            n_fail++; $display("FAIL basic_count_post: got %0d expected 0", out_Count);
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) rec_edge(8'(i));
        n_checks++;
        if (out_Count !== 4'd8 || out_Overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_flags: count=%0d ovf=%b expected 8 1", out_Count, out_Overflow);
        end
        tx_edge;
        capture(-1, -1, 8'h00);
        start_exp(8'h08);
        for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
        n_checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ovf_len: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL ovf_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (out_Count !== 4'd0 || out_Overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: count=%0d ovf=%b expected 0 1", out_Count, out_Overflow);
        end
    endtask

    task automatic test_empty_frame;
        int extra_valid;
        tx_edge;
        capture(2, -1, 8'h00);
        start_exp(8'h00);
        n_checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL empty_len: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL empty_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (fall_cyc != 4 + SEQX) begin
            n_fail++; $display("FAIL empty_busy_fall: cycle %0d expected %0d", fall_cyc, 4 + SEQX);
        end
        extra_valid = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_TxValid || out_Busy) extra_valid++;
            tick;
        end
        n_checks++;
        if (extra_valid != 0) begin
            n_fail++; $display("FAIL empty_ignored_tx: %0d busy/valid cycles after frame, expected 0", extra_valid);
        end
    endtask

    task automatic test_ready_stall;
        rec_edge(8'hAA); rec_edge(8'hBB); rec_edge(8'hCC);
        rdy_low[4 + SEQX] = 1'b1;
        rdy_low[5 + SEQX] = 1'b1;
        tx_edge;
        capture(-1, -1, 8'h00);
        rdy_low[4 + SEQX] = 1'b0;
        rdy_low[5 + SEQX] = 1'b0;
        start_exp(8'h03);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
        n_checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stall_len: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL stall_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (hold_err != 0) begin
            n_fail++; $display("FAIL stall_hold: %0d unstable stalled cycles expected 0", hold_err);
        end
        n_checks++;
        if (fall_cyc != 9 + SEQX) begin
            n_fail++; $display("FAIL stall_busy_fall: cycle %0d expected %0d", fall_cyc, 9 + SEQX);
        end
    endtask

    task automatic test_simultaneous;
        rec_edge(8'h55); rec_edge(8'h66);
        din = 8'h44; rec = 1'b1; tx = 1'b1;
        tick;
        rec = 1'b0; tx = 1'b0;
        n_checks++;
        if (out_Count !== 4'd3) begin
            n_fail++; $display("FAIL simul_count: got %0d expected 3", out_Count);
        end
        capture(-1, 4, 8'h77);
        start_exp(8'h03);
        exp_q.push_back(8'h55); exp_q.push_back(8'h66); exp_q.push_back(8'h44);
        n_checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL simul_len: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL simul_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (out_Count !== 4'd1) begin
            n_fail++; $display("FAIL simul_midframe_count: got %0d expected 1", out_Count);
        end
        tick;
        tx_edge;
        capture(-1, -1, 8'h00);
        start_exp(8'h01);
        exp_q.push_back(8'h77);
        n_checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL next_len: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL next_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        rec_edge(8'h01); rec_edge(8'h02); rec_edge(8'h03); rec_edge(8'h04);
        tx_edge;
        for (int i = 0; i < 5; i++) tick;
        n_checks++;
        if (out_Busy !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", out_Busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_TxValid, out_Busy, out_Overflow} !== 3'b000 || out_TxData !== 8'h00 || out_Count !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid_values: valid=%b busy=%b ovf=%b data=%02h count=%0d, expected all 0",
                     out_TxValid, out_Busy, out_Overflow, out_TxData, out_Count);
        end
        tick; tick;
        rst = 1'b0;
        tick; tick;
        seq_exp = 0;
        tx_edge;
        capture(-1, -1, 8'h00);
        start_exp(8'h00);
        n_checks++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rstmid_len: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rstmid_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_empty_frame;
        test_ready_stall;
        test_simultaneous;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glenn_record_tx.md
# glenn_record_tx

Consumes the minute-record and five-minute-transmit strobes from the timer block. Each record strobe captures one 8-bit sample into an internal buffer. Each transmit strobe sends the buffered samples as a byte-serial frame over a valid/ready link toward the radio front end. It sits between the timer/sensor path and the transmit serializer.

## Interface
- DEPTH, 8: sample buffer entries; power of two, 2..64
- SYNC_BYTE, 8'hA5: first byte of every frame
- in_Clk  input  1  system clock, rising edge
- in_Rst  input  1  asynchronous, active-high reset
- in_1minRecord  input  1  record strobe; level, rising edge significant
- in_5minTransmit  input  1  transmit strobe; level, rising edge significant
- in_Data  input  8  sample value, captured on a record edge
- out_TxData  output  8  frame byte
- out_TxValid  output  1  out_TxData valid
- in_TxReady  input  1  downstream accepts byte when valid&ready
- out_Busy  output  1  frame in progress
- out_Overflow  output  1  sticky: a record edge was dropped because the buffer was full
- out_Count  output  log2(DEPTH)+1  buffer occupancy

## Operation
- Both strobes are treated as levels. Each is registered, and the event is strobe=1 & previous=0.
- The previous-value registers reset to 1. A strobe already high at reset release produces no event.
- Record event, buffer not full: in_Data is written at that clock edge and occupancy increments.
- Record event, buffer full: the sample is dropped and out_Overflow is set. out_Overflow clears only on reset.
- FSM states:
  - IDLE: on a transmit event, latch N = occupancy after any same-edge write, then go to SYNC.
  - SYNC: present SYNC_BYTE; on accept, go to LEN.
  - LEN: present N; on accept, go to DATA, or to DONE if N=0.
  - DATA: present the buffer head; on accept, pop and decrement the remaining count. After the Nth accept, go to DONE.
  - DONE: one cycle, then IDLE.
- out_Busy=1 in every state except IDLE.
- Transmit event while not in IDLE: ignored entirely (not queued).
- Record event during a frame: written if there is space. It is not part of the current frame because N is already latched; it is sent in the next frame.
- Simultaneous record and transmit events in IDLE: the sample is written first and is included in N.
- Simultaneous write and pop in DATA: occupancy is unchanged. Both the write and the pop pointer wrap modulo DEPTH.
- Buffer full when occupancy = DEPTH; empty when 0.
- A frame with N=0 is legal: SYNC, 0x00, DONE.

## Timing
- Reset values: out_TxData=0, out_TxValid=0, out_Busy=0, out_Overflow=0, out_Count=0, FSM=IDLE, pointers=0.
- Reset asserted mid-frame aborts the frame immediately and empties the buffer.
- Transmit event on edge k: out_TxValid=1 with SYNC_BYTE after edge k+1.
- out_TxValid and out_TxData are registered.
- While valid=1 and ready=0, data is held stable and valid is not dropped.
- Full throughput: one byte per cycle while in_TxReady=1.
- Frame length is N+2 bytes (N+3 with the tag). Minimum latency from event to DONE is N+3 cycles.
- out_Count reflects a write or pop one edge after it occurs.

## Configuration
- Macro GLENN_RECORD_TX_SEQ_EN.
- Defined: an extra SEQ state follows LEN and sends an 8-bit frame sequence number.
  - The sequence number resets to 0 and increments on entry to DONE, wrapping 255->0.
  - Every frame, including N=0 frames, carries it and increments it.
- Undefined: no SEQ state, no sequence register; the frame is SYNC, LEN, data.

## Structure
- Package glenn_record_tx_pkg holds:
  - the FSM state encoding (IDLE, SYNC, LEN, SEQ, DATA, DONE)
  - the default SYNC_BYTE
  - the occupancy-width function
- Sub-module glenn_sample_fifo: single-clock, DEPTH×8, with write, pop, full, empty and count, and async active-high reset.
- The top level contains the edge detectors, FSM, output registers and overflow flag.

## Test plan
- Reset release, then three record edges with data 0x11, 0x22, 0x33, then a transmit edge, ready held 1 -> bytes A5, 03, 11, 22, 33 on consecutive cycles; out_Busy falls after DONE; out_Count=0.
- DEPTH=8, nine record edges with data 0x01..0x09 -> out_Count=8, out_Overflow=1; next frame is A5, 08, 01..08.
- Transmit edge with the buffer empty -> A5, 00; a second transmit edge arriving while busy is ignored, so only one frame is sent.
- Ready toggled 1,0,0,1 during DATA -> out_TxData stable and valid held while ready=0; no bytes lost or duplicated.
- Record and transmit edges on the same cycle with 2 entries stored, data 0x44 -> LEN=03 and 0x44 is the last data byte; a record edge mid-frame appears in the following frame.
- Reset asserted during DATA, then released -> outputs take reset values and the next transmit edge sends A5, 00. With GLENN_RECORD_TX_SEQ_EN defined, frames 1..3 carry 00, 01, 02 after LEN.
